// File: rtl/anton_neopixel_frame_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the NeoPixel frame sequencer.
// Status software decodes seqState with these values, so the encoding is fixed.
package anton_neopixel_frame_sequencer_pkg;

    localparam logic [2:0] ENUM_SEQ_IDLE   = 3'd0;
    localparam logic [2:0] ENUM_SEQ_INIT   = 3'd1;
    localparam logic [2:0] ENUM_SEQ_STREAM = 3'd2;
    localparam logic [2:0] ENUM_SEQ_SYNC   = 3'd3;
    localparam logic [2:0] ENUM_SEQ_GAP    = 3'd4;

    localparam int FRAME_GAP_DEFAULT = 0;

    typedef enum logic [2:0] {
        SEQ_IDLE   = ENUM_SEQ_IDLE,
        SEQ_INIT   = ENUM_SEQ_INIT,
        SEQ_STREAM = ENUM_SEQ_STREAM,
        SEQ_SYNC   = ENUM_SEQ_SYNC,
        SEQ_GAP    = ENUM_SEQ_GAP
    } seq_state_e;

    function automatic int gap_cnt_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/anton_neopixel_gap_timer.sv
// Inter-frame gap down-counter: start loads GAP, expired flags the last gap cycle.
// Occupying the GAP state for exactly GAP cycles needs expiry at count 1, not 0.
module anton_neopixel_gap_timer
    import anton_neopixel_frame_sequencer_pkg::*;
#(
    parameter int GAP = 1,
    parameter int W   = gap_cnt_width(GAP)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    output logic expired_o
);

    localparam logic [W-1:0] LOAD = W'(GAP);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame-level controller: init/run handshakes, latch wait, optional gap, frame count.
// Bank swapping is built only when ANTON_NEOPIXEL_DOUBLE_BUFFER_EN is defined.
module anton_neopixel_frame_sequencer
    import anton_neopixel_frame_sequencer_pkg::*;
#(
    parameter int FRAME_GAP  = FRAME_GAP_DEFAULT,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk6_4mhz,
    input  logic                  reset,
    input  logic                  regCtrlInit,
    input  logic                  regCtrlRun,
    input  logic                  regCtrlLoop,
    input  logic                  startPulse,
    input  logic                  streamPixelOf,
    input  logic                  streamSyncOf,
    input  logic                  initSlowDone,
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
    input  logic                  swapReq,
    output logic                  bankSelect,
`endif
    output logic                  initSlow,
    output logic                  streamRun,
    output logic                  frameDone,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] frameCount,
    output logic [2:0]            seqState
);

    seq_state_e            state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  frame_done_d;
    logic                  gap_expired;
    logic                  init_q, run_q, done_q, busy_q;
    logic [COUNT_BITS-1:0] count_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (regCtrlRun && (regCtrlLoop || pend_q || startPulse)) begin
                    state_d = SEQ_STREAM;
                end
            end
            SEQ_INIT: begin
                if (initSlowDone) begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_STREAM: begin
                if (!regCtrlRun) begin
                    state_d = SEQ_INIT;
                end else if (streamPixelOf) begin
                    state_d = SEQ_SYNC;
                end
            end
            SEQ_SYNC: begin
                // The latch period ending means the frame is complete, whatever else happens now.
                if (streamSyncOf) begin
                    frame_done_d = 1'b1;
                    if (regCtrlRun && regCtrlLoop) begin
                        state_d = (FRAME_GAP > 0) ? SEQ_GAP : SEQ_STREAM;
                    end else if (pend_q) begin
                        state_d = SEQ_STREAM;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
                if (!regCtrlRun) begin
                    state_d = SEQ_INIT;
                end
            end
            SEQ_GAP: begin
                if (!regCtrlRun) begin
                    state_d = SEQ_INIT;
                end else if (gap_expired) begin
                    state_d = regCtrlLoop ? SEQ_STREAM : SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (regCtrlInit) begin
            state_d = SEQ_INIT;
        end
        if (state_d == SEQ_STREAM && state_q != SEQ_STREAM) begin
            pend_d = 1'b0;
        end
        // A start that launches a frame straight from IDLE is consumed, not queued.
        if (startPulse && !(state_q == SEQ_IDLE && state_d == SEQ_STREAM)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            pend_q  <= 1'b0;
            init_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            init_q  <= (state_d == SEQ_INIT);
            run_q   <= (state_d == SEQ_STREAM) || (state_d == SEQ_SYNC);
            busy_q  <= (state_d != SEQ_IDLE);
            done_q  <= frame_done_d;
            if (frame_done_d) begin
                count_q <= count_q + COUNT_BITS'(1);
            end
        end
    end

    generate
        if (FRAME_GAP > 0) begin : g_gap
            anton_neopixel_gap_timer #(
                .GAP (FRAME_GAP)
            ) u_gap_timer (
                .clk_i     (clk6_4mhz),
                .reset_i   (reset),
                .start_i   (state_q == SEQ_SYNC && state_d == SEQ_GAP),
                .expired_o (gap_expired)
            );
        end else begin : g_no_gap
            assign gap_expired = 1'b1;
        end
    endgenerate

`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
    logic bank_q, swap_pend_q, swap_now;

    // Only an already-pending request is honoured, so one arriving on the boundary waits.
    assign swap_now = swap_pend_q &&
                      (frame_done_d || state_q == SEQ_IDLE || state_q == SEQ_INIT);

    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            bank_q      <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            bank_q      <= bank_q ^ swap_now;
            swap_pend_q <= (swap_pend_q && !swap_now) || swapReq;
        end
    end

    assign bankSelect = bank_q;
`endif

    assign initSlow   = init_q;
    assign streamRun  = run_q;
    assign frameDone  = done_q;
    assign busy       = busy_q;
    assign frameCount = count_q;
    assign seqState   = state_q;

endmodule

// File: tb/tb_anton_neopixel_frame_sequencer.sv
// Directed bench for the frame sequencer (FRAME_GAP=10, 3-bit counter so it wraps).
`timescale 1ns/1ps
module tb_anton_neopixel_frame_sequencer;

    localparam int GAP = 10;
    localparam int CB  = 3;

    logic          clk6_4mhz = 1'b0;
    logic          reset = 1'b1;
    logic          regCtrlInit = 1'b0, regCtrlRun = 1'b0, regCtrlLoop = 1'b0;
    logic          startPulse = 1'b0, streamPixelOf = 1'b0, streamSyncOf = 1'b0;
    logic          initSlowDone = 1'b0;
    logic          initSlow, streamRun, frameDone, busy;
    logic [CB-1:0] frameCount;
    logic [2:0]    seqState;
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
    logic          swapReq = 1'b0;
    logic          bankSelect;
`endif

    int            errors = 0;
    int            checks = 0;
    logic [CB-1:0] exp_cnt = '0;

    always #78 clk6_4mhz = ~clk6_4mhz;

    anton_neopixel_frame_sequencer #(
        .FRAME_GAP  (GAP),
        .COUNT_BITS (CB)
    ) dut (
        .clk6_4mhz     (clk6_4mhz),
        .reset         (reset),
        .regCtrlInit   (regCtrlInit),
        .regCtrlRun    (regCtrlRun),
        .regCtrlLoop   (regCtrlLoop),
        .startPulse    (startPulse),
        .streamPixelOf (streamPixelOf),
        .streamSyncOf  (streamSyncOf),
        .initSlowDone  (initSlowDone),
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
        .swapReq       (swapReq),
        .bankSelect    (bankSelect),
`endif
        .initSlow      (initSlow),
        .streamRun     (streamRun),
        .frameDone     (frameDone),
        .busy          (busy),
        .frameCount    (frameCount),
        .seqState      (seqState)
    );

    task automatic step();
        @(posedge clk6_4mhz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (seqState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", seqState); end
        checks++; if (initSlow !== 1'b0) begin errors++; $display("FAIL reset_initSlow: got %b want 0", initSlow); end
        checks++; if (streamRun !== 1'b0) begin errors++; $display("FAIL reset_streamRun: got %b want 0", streamRun); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_frameDone: got %b want 0", frameDone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frameCount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frameCount); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_init();
        regCtrlInit = 1'b1; step(); regCtrlInit = 1'b0;
        checks++; if (seqState !== 3'd1) begin errors++; $display("FAIL init_enter: state %0d want 1", seqState); end
        checks++; if (initSlow !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL init_outputs: initSlow=%b busy=%b want 1 1", initSlow, busy); end
        repeat (3) step();
        checks++; if (seqState !== 3'd1) begin errors++; $display("FAIL init_hold: state %0d want 1", seqState); end
        initSlowDone = 1'b1; step(); initSlowDone = 1'b0;
        checks++; if (seqState !== 3'd0 || initSlow !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL init_done: state=%0d initSlow=%b busy=%b want 0 0 0", seqState, initSlow, busy);
        end
    endtask

    task automatic test_single_frame();
        int bad;
        int pulses;
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        checks++; if (seqState !== 3'd2 || streamRun !== 1'b1) begin errors++; $display("FAIL single_start: state=%0d run=%b want 2 1", seqState, streamRun); end
        repeat (4) step();
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;     // now at t0+1
        checks++; if (seqState !== 3'd3 || streamRun !== 1'b1) begin errors++; $display("FAIL single_sync: state=%0d run=%b want 3 1", seqState, streamRun); end
        bad = 0;
        repeat (1958) begin
            step();
            if (frameDone !== 1'b0 || seqState !== 3'd3 || streamRun !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_latch_wait: %0d bad cycles want 0", bad); end
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;       // now at t0+1960
        exp_cnt = exp_cnt + 3'd1;
        pulses = (frameDone === 1'b1) ? 1 : 0;
        checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL single_done: frameDone=%b want 1", frameDone); end
        checks++; if (frameCount !== exp_cnt) begin errors++; $display("FAIL single_count: got %0d want %0d", frameCount, exp_cnt); end
        checks++; if (seqState !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: state=%0d busy=%b want 0 0", seqState, busy); end
        repeat (3) begin step(); if (frameDone === 1'b1) pulses++; end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse_once: %0d pulses want 1", pulses); end
    endtask

    task automatic test_loop_gap();
        int low;
        regCtrlRun = 1'b1; regCtrlLoop = 1'b1; step();
        checks++; if (seqState !== 3'd2) begin errors++; $display("FAIL loop_start: state %0d want 2", seqState); end
        for (int f = 0; f < 3; f++) begin
            repeat (3) step();
            streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
            repeat (2) step();
            if (f == 2) regCtrlLoop = 1'b0;
            streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
            exp_cnt = exp_cnt + 3'd1;
            checks++; if (frameDone !== 1'b1 || frameCount !== exp_cnt) begin
                errors++; $display("FAIL loop_done_%0d: done=%b count=%0d want 1 %0d", f, frameDone, frameCount, exp_cnt);
            end
            if (f < 2) begin
                low = 0;
                while (streamRun === 1'b0 && low < 50) begin low++; step(); end
                checks++; if (low != GAP || seqState !== 3'd2) begin
                    errors++; $display("FAIL loop_gap_%0d: low=%0d state=%0d want %0d 2", f, low, seqState, GAP);
                end
            end else begin
                checks++; if (seqState !== 3'd0) begin errors++; $display("FAIL loop_end: state %0d want 0", seqState); end
            end
        end
    endtask

    task automatic test_abort();
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        repeat (3) step();
        regCtrlRun = 1'b0; step();
        checks++; if (seqState !== 3'd1 || initSlow !== 1'b1 || streamRun !== 1'b0) begin
            errors++; $display("FAIL abort_state: state=%0d init=%b run=%b want 1 1 0", seqState, initSlow, streamRun);
        end
        step();
        checks++; if (frameDone !== 1'b0 || frameCount !== exp_cnt) begin
            errors++; $display("FAIL abort_no_count: done=%b count=%0d want 0 %0d", frameDone, frameCount, exp_cnt);
        end
        initSlowDone = 1'b1; step(); initSlowDone = 1'b0;
        regCtrlRun = 1'b1;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        regCtrlRun = 1'b0; streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        checks++; if (seqState !== 3'd1) begin errors++; $display("FAIL abort_beats_pixel: state %0d want 1", seqState); end
        initSlowDone = 1'b1; step(); initSlowDone = 1'b0;
        checks++; if (seqState !== 3'd0) begin errors++; $display("FAIL abort_recover: state %0d want 0", seqState); end
    endtask

    task automatic test_pending_no_run();
        regCtrlRun = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        step();
        checks++; if (seqState !== 3'd0) begin errors++; $display("FAIL pend_hold: state %0d want 0", seqState); end
        regCtrlRun = 1'b1; step();
        checks++; if (seqState !== 3'd2) begin errors++; $display("FAIL pend_launch: state %0d want 2", seqState); end
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        step();
        checks++; if (seqState !== 3'd0 || frameCount !== exp_cnt) begin
            errors++; $display("FAIL pend_consumed: state=%0d count=%0d want 0 %0d", seqState, frameCount, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        step();
        startPulse = 1'b1; step(); startPulse = 1'b0;
        step();
        startPulse = 1'b1; step(); startPulse = 1'b0;
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        checks++; if (frameDone !== 1'b1 || seqState !== 3'd2 || streamRun !== 1'b1) begin
            errors++; $display("FAIL b2b_second: done=%b state=%0d run=%b want 1 2 1", frameDone, seqState, streamRun);
        end
        repeat (3) step();
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        checks++; if (frameDone !== 1'b1 || seqState !== 3'd0) begin
            errors++; $display("FAIL b2b_end: done=%b state=%0d want 1 0", frameDone, seqState);
        end
        step();
        checks++; if (seqState !== 3'd0 || frameCount !== exp_cnt) begin
            errors++; $display("FAIL b2b_count: state=%0d count=%0d want 0 %0d", seqState, frameCount, exp_cnt);
        end
    endtask

    task automatic test_sync_vs_init();
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        streamSyncOf = 1'b1; regCtrlInit = 1'b1; step();
        streamSyncOf = 1'b0; regCtrlInit = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        // Eighth completed frame: a 3-bit counter must read 0 here.
        checks++; if (seqState !== 3'd1 || frameDone !== 1'b1 || frameCount !== exp_cnt) begin
            errors++; $display("FAIL sync_init: state=%0d done=%b count=%0d want 1 1 %0d", seqState, frameDone, frameCount, exp_cnt);
        end
        initSlowDone = 1'b1; step(); initSlowDone = 1'b0;
    endtask

`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
    task automatic test_swap();
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        swapReq = 1'b1; step(); swapReq = 1'b0;
        repeat (3) step();
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        checks++; if (bankSelect !== 1'b0) begin errors++; $display("FAIL swap_early: bank=%b want 0", bankSelect); end
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        checks++; if (bankSelect !== 1'b1 || frameDone !== 1'b1) begin
            errors++; $display("FAIL swap_boundary: bank=%b done=%b want 1 1", bankSelect, frameDone);
        end
        swapReq = 1'b1; step(); swapReq = 1'b0;
        step();
        checks++; if (bankSelect !== 1'b0) begin errors++; $display("FAIL swap_idle: bank=%b want 0", bankSelect); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        regCtrlRun = 1'b1; regCtrlLoop = 1'b0;
        startPulse = 1'b1; step(); startPulse = 1'b0;
        streamPixelOf = 1'b1; step(); streamPixelOf = 1'b0;
        streamSyncOf = 1'b1; step(); streamSyncOf = 1'b0;
        exp_cnt = exp_cnt + 3'd1;
        checks++; if (frameCount !== exp_cnt) begin errors++; $display("FAIL pre_reset_count: got %0d want %0d", frameCount, exp_cnt); end
        startPulse = 1'b1; step(); startPulse = 1'b0;
        step();
        reset = 1'b1; step();
        exp_cnt = '0;
        checks++; if (seqState !== 3'd0 || streamRun !== 1'b0 || busy !== 1'b0 || frameCount !== exp_cnt) begin
            errors++; $display("FAIL reset_mid_frame: state=%0d run=%b busy=%b count=%0d want 0 0 0 0", seqState, streamRun, busy, frameCount);
        end
        reset = 1'b0; regCtrlRun = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_frame();
        test_loop_gap();
        test_abort();
        test_pending_no_run();
        test_back_to_back();
        test_sync_vs_init();
`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
        test_swap();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_frame_sequencer.md
# anton_neopixel_frame_sequencer

Frame-level controller for the NeoPixel stream datapath.
- Sits between the APB control registers and the stream logic, and drives its run, init and frame handshakes.
- Decides when a frame starts, waits out the latch/reset period, inserts an optional inter-frame gap and counts finished frames.
- Queues software start requests and, when compiled in, swaps display banks only at frame boundaries.

## Interface
Parameters:
- FRAME_GAP, 0, extra idle ticks inserted between frames in loop mode (0 = back-to-back)
- COUNT_BITS, 16, width of the frame counter

Ports:
- clk6_4mhz  input  1  stream clock, all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- regCtrlInit  input  1  software init request (level)
- regCtrlRun  input  1  software run enable (level)
- regCtrlLoop  input  1  continuous-frame mode (level)
- startPulse  input  1  one-cycle single-frame start request
- streamPixelOf  input  1  last bit of last pixel transmitted (from stream logic)
- streamSyncOf  input  1  reset/latch delay complete (from stream logic)
- initSlowDone  input  1  stream logic finished index init
- initSlow  output  1  init command to stream logic
- streamRun  output  1  run enable to stream logic
- frameDone  output  1  one-cycle pulse per completed frame
- busy  output  1  high in every state except IDLE
- frameCount  output  COUNT_BITS  completed frames, wraps
- seqState  output  3  current state, for status register
- bankSelect  output  1  active display bank (only with macro)
- swapReq  input  1  one-cycle bank swap request (only with macro)

## Operation
- States:
  - IDLE=0
  - INIT=1
  - STREAM=2
  - SYNC=3
  - GAP=4
- All outputs decode from the state register or registered flags. No combinational input-to-output paths.
- IDLE:
  - Goes to INIT when regCtrlInit=1.
  - Goes to STREAM when regCtrlRun=1 and (regCtrlLoop=1 or startPending=1). Entering STREAM clears startPending.
- INIT:
  - initSlow=1.
  - Goes to IDLE on the cycle initSlowDone=1.
- STREAM:
  - streamRun=1.
  - Goes to SYNC on streamPixelOf=1.
  - Goes to INIT if regCtrlRun drops (abort). No frameDone and no count on abort.
- SYNC:
  - streamRun=1 so the stream logic counts its reset delay.
  - On streamSyncOf=1: frameDone pulses next cycle and frameCount increments.
  - Next state on streamSyncOf=1:
    - GAP, if regCtrlRun && regCtrlLoop && FRAME_GAP>0.
    - STREAM, if regCtrlRun && regCtrlLoop && FRAME_GAP==0.
    - STREAM, if startPending=1 (this clears startPending).
    - IDLE, otherwise.
  - Goes to INIT if regCtrlRun drops.
- GAP:
  - streamRun=0.
  - Counts FRAME_GAP cycles, then goes to STREAM if regCtrlRun && regCtrlLoop, else IDLE.
  - Goes to INIT if regCtrlRun drops.
- regCtrlInit=1 forces INIT from any state and has the highest priority.
- startPulse in any state other than IDLE sets startPending. The queue is one deep, so extra pulses merge.
- startPulse in IDLE with regCtrlRun=1 starts a frame immediately.
- startPulse with regCtrlRun=0 is held pending.
- frameCount wraps from all-ones to 0. No saturation.

## Timing
- Reset values:
  - seqState=IDLE
  - initSlow=0, streamRun=0, frameDone=0, busy=0
  - frameCount=0, startPending=0, gap counter=0, bankSelect=0
- Every transition takes effect one cycle after the triggering input is sampled.
- streamPixelOf at cycle N: state is SYNC at N+1. streamRun stays 1 without a glitch.
- streamSyncOf at cycle N: frameDone=1 and frameCount updated at N+1. Next-frame streamRun is 1 from N+1 with no gap when FRAME_GAP=0.
- GAP lasts exactly FRAME_GAP cycles with streamRun=0.
- initSlowDone at N: IDLE at N+1. A frame can start at N+2 at the earliest.
- streamPixelOf and regCtrlRun drop in the same cycle: abort wins (INIT).
- streamSyncOf and regCtrlInit in the same cycle: INIT wins, but frameDone and the count still occur because the frame completed.
- reset asserted mid-frame: all state returns to reset values on the next edge. The stream logic is not reinitialised until the next INIT.

## Configuration
- ANTON_NEOPIXEL_DOUBLE_BUFFER_EN defined:
  - bankSelect and swapReq ports exist.
  - swapReq sets swapPending.
  - bankSelect toggles and swapPending clears on the frameDone cycle, or on the next cycle if the block is in IDLE or INIT.
  - Swap and frameDone in the same cycle: the new request is kept pending for the following boundary.
- Not defined:
  - Ports are omitted and no swap logic is generated.

## Structure
- anton_common.vh holds:
  - the ENUM_SEQ_IDLE/INIT/STREAM/SYNC/GAP state constants
  - the FRAME_GAP default
- Sub-module anton_neopixel_gap_timer: loadable down-counter with start and expired outputs, sized with CLOG2(FRAME_GAP+1), and omitted when FRAME_GAP=0.

## Test plan
- Reset, then regCtrlInit=1 for 1 cycle → INIT, initSlow=1 until initSlowDone, then IDLE.
- regCtrlRun=1, startPulse once; drive streamPixelOf at t0 and streamSyncOf at t0+1959 → frameDone pulses once at t0+1960, frameCount=1, returns to IDLE.
- Loop mode, FRAME_GAP=10, 3 frames → streamRun low for exactly 10 cycles between frames, frameCount=3.
- regCtrlRun dropped during STREAM → INIT, no frameDone, frameCount unchanged.
- startPulse twice during a frame → exactly one extra frame follows, then IDLE.
- With ANTON_NEOPIXEL_DOUBLE_BUFFER_EN: swapReq mid-frame → bankSelect toggles in the same cycle as frameDone, not before.
